// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the count-width helper.
`timescale 1ns/1ps
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int count_width(input int w);
    if ($clog2(w) < 1) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder. The ovf signal exists only when
// SERIAL_ADDER_OVF_EN is defined.
`timescale 1ns/1ps
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder reused on every serial step.
`timescale 1ns/1ps
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles.
// Defining SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
`timescale 1ns/1ps
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);

  localparam int CW = count_width(WIDTH);
  localparam int AW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  // Only the first WIDTH-1 sum bits need staging; the last one goes straight to sum.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder_cell u_fa (
    .a   (sha_q[0]),
    .b   (shb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sha_d   = bus.a;
          shb_d   = bus.b;
          carry_d = bus.cin;
          count_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        carry_d = fa_co;
        count_d = count_q + CW'(1'b1);
        acc_d   = AW'({fa_s, acc_q} >> 1);
        if (count_q == LAST) begin
          state_d = DONE;
          sum_d   = {fa_s, acc_q};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this final step
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      carry_q <= 1'b0;
      sha_q   <= {WIDTH{1'b0}};
      shb_q   <= {WIDTH{1'b0}};
      acc_q   <= {AW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=4); ovf is checked when
// SERIAL_ADDER_OVF_EN is defined.
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk;
  logic reset;

  serial_adder_if #(.WIDTH(4)) bus ();

  serial_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_issued = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: actual=1 required=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sum", {28'd0, bus.sum}, {28'd0, e.sum});
        chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.done === 1'b1);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                        input logic [3:0] es, input logic ec, input logic eo);
    bus.a = ia; bus.b = ib; bus.cin = ic; bus.start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, ovf: eo});
    n_issued++;
    @(negedge clk);
    bus.start = 1'b0;
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0; bus.cin = 1'b0;
    #3 reset = 1'b1;
    #4 reset = 1'b0;
    @(negedge clk);
    chk("rst_sum",  {28'd0, bus.sum},  32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // 3 + 5: exact latency check
    bus.a = 4'd3; bus.b = 4'd5; bus.cin = 1'b0; bus.start = 1'b1;
    exp_q.push_back('{sum: 4'd8, cout: 1'b0, ovf: 1'b1});
    n_issued++;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    chk("lat_busy_k", {31'd0, bus.busy}, 32'd1);
    chk("lat_done_k", {31'd0, bus.done}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("lat_busy_shift", {31'd0, bus.busy}, 32'd1);
      chk("lat_done_shift", {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    chk("lat_done_k4", {31'd0, bus.done}, 32'd1);
    chk("lat_busy_k4", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("lat_done_k5", {31'd0, bus.done}, 32'd0);
    chk("lat_busy_k5", {31'd0, bus.busy}, 32'd0);

    // back-to-back: second start lands in the first IDLE cycle
    run_op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
    run_op(4'd9,  4'd7, 1'b1, 4'd1, 1'b1, 1'b0);

    // start held high through SHIFT and DONE, operands changed mid-flight
    bus.a = 4'd2; bus.b = 4'd3; bus.cin = 1'b0; bus.start = 1'b1;
    exp_q.push_back('{sum: 4'd5, cout: 1'b0, ovf: 1'b0});
    n_issued++;
    @(negedge clk);
    bus.a = 4'd15; bus.b = 4'd15; bus.cin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_sum_mid", {28'd0, bus.sum}, 32'd1);
    wait_done();
    @(negedge clk);
    chk("held_start_idle", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_sum_after", {28'd0, bus.sum}, 32'd5);

    // asynchronous abort after the second SHIFT edge of 6 + 6
    bus.a = 4'd6; bus.b = 4'd6; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_sum",  {28'd0, bus.sum},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_restart", {31'd0, bus.busy}, 32'd0);
    run_op(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);

    // signed overflow boundary cases
    run_op(4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1);
    run_op(4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("done_count", n_done, n_issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that drives a single 1-bit full-add cell over WIDTH clock cycles, LSB first, with a registered carry.
- Sits as the sequencing stage around the adder cell. It loads two operands, shifts operand bits into the cell and collects each sum bit into a result register. The carry-out feeds back as the next carry-in.
- Trades area for latency against the combinational ripple-carry adder. Operands are WIDTH bits, unsigned.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the start edge
- b  input  WIDTH  operand B; captured on the start edge
- cin  input  1  initial carry-in; captured on the start edge
- busy  output  1  high while state is SHIFT or DONE
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry-out

Interface (already decided):
- One clock, clk.
- Reset is asynchronous and active-high, port name reset.

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE, count=0, carry=0.
  - Shift registers cleared; sum=0, cout=0, busy=0, done=0.
  - Reset asserted mid-SHIFT aborts the operation. No done is produced for it.
- State machine:
  - IDLE -> SHIFT on the edge where start=1. That edge loads shA<=a, shB<=b, carry<=cin, count<=0.
  - SHIFT, each edge:
    - s = shA[0]^shB[0]^carry; c = majority(shA[0], shB[0], carry).
    - Result register shifts right with s entering the MSB.
    - shA and shB shift right (zero fill); carry<=c; count<=count+1.
    - SHIFT -> DONE on the edge where count==WIDTH-1. That edge writes the final sum bit; cout<=c.
  - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Latency:
  - start sampled at edge k; SHIFT occupies edges k+1 .. k+WIDTH.
  - done is high in the cycle between edges k+WIDTH and k+WIDTH+1.
  - Back-to-back issue: next start is accepted at edge k+WIDTH+2, i.e. the first IDLE cycle.
- start handling:
  - start while busy=1, including during DONE, is ignored. It is not queued.
  - Changes to a, b or cin after the start edge have no effect on the operation in progress.
- Output hold:
  - sum and cout change only on the final SHIFT edge.
  - They hold their value until the next operation completes or reset.
  - The intermediate shifting is done in an internal register and copied to sum at completion, so sum never shows partial values.
- Width rules:
  - count is clog2(WIDTH) bits.
  - The result is modulo 2^WIDTH, with the carry reported on cout.
- done and busy are decoded from state (registered-state outputs, glitch-free).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow: carry into MSB XOR carry out of MSB.
  - ovf is registered on the final SHIFT edge alongside cout, reset to 0, and held like sum.
- Undefined: port ovf is absent. No extra logic.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default WIDTH constant
  - count-width function (clog2)
- Sub-module full_adder_cell (a, b, cin -> s, co): pure combinational 1-bit full adder, instantiated once in the datapath.

Test Plan (WIDTH=4):
- reset pulse mid-idle, then release -> sum=0, cout=0, busy=0, done=0; no activity until start.
- a=3, b=5, cin=0, start at edge k -> busy high from k; done high only in cycle after edge k+4; sum=8, cout=0.
- a=15, b=1, cin=0 -> sum=0, cout=1; a=9, b=7, cin=1 -> sum=1, cout=1 (back-to-back, second start issued at first IDLE cycle).
- start held high continuously during an operation, with a and b changed mid-operation -> single done per accepted start; result uses operands captured on the start edge only.
- reset asserted asynchronously after the 2nd SHIFT edge of a=6, b=6 -> immediate IDLE, sum=0, no done pulse; next start with a=2, b=2 gives sum=4.
- With SERIAL_ADDER_OVF_EN: a=7, b=1 -> sum=8, cout=0, ovf=1; a=15, b=15 -> sum=14, cout=1, ovf=0.
